// File: rtl/fetch_pkg.sv
// fetch_pkg: shared constants and types for the fetch stage.
//   FETCH_WIDTH  - default data bits per wavefront entry
//   FETCH_DEPTH  - default number of wavefront entries
//   FETCH_ADDR_W - default wavefront id width
//   wf_id_t      - wavefront id type
package fetch_pkg;

    localparam int FETCH_WIDTH  = 11;
    localparam int FETCH_DEPTH  = 40;
    localparam int FETCH_ADDR_W = 6;
    localparam int FETCH_CNT_W  = 7;

    typedef logic [FETCH_ADDR_W-1:0] wf_id_t;

endpackage

// File: rtl/wf_regblock_rdport.sv
// wf_regblock_rdport: one registered read port of the wavefront register block.
// Ports:
//   clk, rst            - clock, asynchronous active-low reset
//   rd_en, rd_addr      - read request and entry address
//   mem, vld            - current (pre-edge) entry data and valid vector
//   wr0_*, wr1_*        - write ports, used for same-edge forwarding
//   inv_en, inv_addr    - single-entry invalidate, used for forwarding
//   clear_all           - bulk invalidate, used for forwarding
//   rd_data, rd_valid   - registered read result (data zeroed when invalid)
//   rd_ack              - one-cycle pulse when rd_data/rd_valid were updated
module wf_regblock_rdport
    import fetch_pkg::*;
#(
    parameter int WIDTH  = FETCH_WIDTH,
    parameter int DEPTH  = FETCH_DEPTH,
    parameter int ADDR_W = FETCH_ADDR_W,
    parameter bit BYPASS = 1'b1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        rd_en,
    input  logic [ADDR_W-1:0]           rd_addr,
    input  logic [DEPTH-1:0][WIDTH-1:0] mem,
    input  logic [DEPTH-1:0]            vld,
    input  logic                        wr0_en,
    input  logic [ADDR_W-1:0]           wr0_addr,
    input  logic [WIDTH-1:0]            wr0_data,
    input  logic                        wr1_en,
    input  logic [ADDR_W-1:0]           wr1_addr,
    input  logic [WIDTH-1:0]            wr1_data,
    input  logic                        inv_en,
    input  logic [ADDR_W-1:0]           inv_addr,
    input  logic                        clear_all,
    output logic [WIDTH-1:0]            rd_data,
    output logic                        rd_valid,
    output logic                        rd_ack
);

    logic              in_range;
    logic [ADDR_W-1:0] idx;
    logic [WIDTH-1:0]  cur_data;
    logic              cur_valid;
    logic [WIDTH-1:0]  fwd_data;
    logic              fwd_valid;
    logic [WIDTH-1:0]  res_data;
    logic              res_valid;

    // Out-of-range addresses are steered to entry 0 so the array index stays
    // legal; their result is forced invalid below.
    always_comb begin
        in_range  = ({1'b0, rd_addr} < (ADDR_W+1)'(DEPTH));
        idx       = in_range ? rd_addr : '0;
        cur_data  = mem[idx];
        cur_valid = vld[idx] & in_range;
    end

    // Forwarded post-edge state: same precedence as the array update
    // (clear_all > inv > wr1 > wr0). Invalidation leaves data untouched,
    // which is harmless because invalid results read as zero.
    always_comb begin
        fwd_data  = cur_data;
        fwd_valid = cur_valid;
        if (clear_all) begin
            fwd_valid = 1'b0;
        end else if (inv_en && inv_addr == rd_addr) begin
            fwd_valid = 1'b0;
        end else if (wr1_en && wr1_addr == rd_addr && in_range) begin
            fwd_data  = wr1_data;
            fwd_valid = 1'b1;
        end else if (wr0_en && wr0_addr == rd_addr && in_range) begin
            fwd_data  = wr0_data;
            fwd_valid = 1'b1;
        end
    end

    always_comb begin
        res_valid = BYPASS ? fwd_valid : cur_valid;
        res_data  = res_valid ? (BYPASS ? fwd_data : cur_data) : '0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
            rd_ack   <= 1'b0;
        end else begin
            rd_ack <= rd_en;
            if (rd_en) begin
                rd_data  <= res_data;
                rd_valid <= res_valid;
            end
        end
    end

endmodule

// File: rtl/wf_regblock.sv
// wf_regblock: per-wavefront state register block for the fetch stage.
// Ports:
//   clk, rst               - clock, asynchronous active-low reset
//   wr0_en/addr/data       - write port 0 (lower priority)
//   wr1_en/addr/data       - write port 1 (higher priority)
//   inv_en, inv_addr       - invalidate one entry
//   clear_all              - invalidate every entry
//   rd_en, rd_addr         - NUM_RD read requests, addresses packed per port
//   rd_data, rd_valid      - packed registered read results
//   rd_ack                 - per-port pulse marking an updated result
//   valid_count            - registered number of valid entries
module wf_regblock
    import fetch_pkg::*;
#(
    parameter int WIDTH  = FETCH_WIDTH,
    parameter int DEPTH  = FETCH_DEPTH,
    parameter int ADDR_W = FETCH_ADDR_W,
    parameter int NUM_RD = 2,
    parameter int CNT_W  = FETCH_CNT_W,
    parameter bit BYPASS = 1'b1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr0_en,
    input  logic [ADDR_W-1:0]        wr0_addr,
    input  logic [WIDTH-1:0]         wr0_data,
    input  logic                     wr1_en,
    input  logic [ADDR_W-1:0]        wr1_addr,
    input  logic [WIDTH-1:0]         wr1_data,
    input  logic                     inv_en,
    input  logic [ADDR_W-1:0]        inv_addr,
    input  logic                     clear_all,
    input  logic [NUM_RD-1:0]        rd_en,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*WIDTH-1:0]  rd_data,
    output logic [NUM_RD-1:0]        rd_valid,
    output logic [NUM_RD-1:0]        rd_ack,
    output logic [CNT_W-1:0]         valid_count
);

    logic [DEPTH-1:0][WIDTH-1:0] mem;
    logic [DEPTH-1:0][WIDTH-1:0] mem_nxt;
    logic [DEPTH-1:0]            vld;
    logic [DEPTH-1:0]            vld_nxt;

    function automatic logic [CNT_W-1:0] popcount(input logic [DEPTH-1:0] v);
        logic [CNT_W-1:0] n;
        n = '0;
        for (int i = 0; i < DEPTH; i++) begin
            n = n + CNT_W'(v[i]);
        end
        return n;
    endfunction

    // Per-entry next state. Addresses >= DEPTH never match an entry index,
    // so out-of-range writes and invalidates fall through untouched.
    // A suppressed write (by clear_all or inv) leaves the data unchanged.
    always_comb begin
        mem_nxt = mem;
        vld_nxt = vld;
        for (int e = 0; e < DEPTH; e++) begin
            if (clear_all) begin
                vld_nxt[e] = 1'b0;
            end else if (inv_en && inv_addr == ADDR_W'(e)) begin
                vld_nxt[e] = 1'b0;
            end else if (wr1_en && wr1_addr == ADDR_W'(e)) begin
                mem_nxt[e] = wr1_data;
                vld_nxt[e] = 1'b1;
            end else if (wr0_en && wr0_addr == ADDR_W'(e)) begin
                mem_nxt[e] = wr0_data;
                vld_nxt[e] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem         <= '0;
            vld         <= '0;
            valid_count <= '0;
        end else begin
            mem         <= mem_nxt;
            vld         <= vld_nxt;
            valid_count <= popcount(vld_nxt);
        end
    end

    for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
        wf_regblock_rdport #(
            .WIDTH  (WIDTH),
            .DEPTH  (DEPTH),
            .ADDR_W (ADDR_W),
            .BYPASS (BYPASS)
        ) u_rdport (
            .clk       (clk),
            .rst       (rst),
            .rd_en     (rd_en[p]),
            .rd_addr   (rd_addr[p*ADDR_W +: ADDR_W]),
            .mem       (mem),
            .vld       (vld),
            .wr0_en    (wr0_en),
            .wr0_addr  (wr0_addr),
            .wr0_data  (wr0_data),
            .wr1_en    (wr1_en),
            .wr1_addr  (wr1_addr),
            .wr1_data  (wr1_data),
            .inv_en    (inv_en),
            .inv_addr  (inv_addr),
            .clear_all (clear_all),
            .rd_data   (rd_data[p*WIDTH +: WIDTH]),
            .rd_valid  (rd_valid[p]),
            .rd_ack    (rd_ack[p])
        );
    end

endmodule

// File: doc/wf_regblock.md
Name: wf_regblock

Overview:
Parametrised per-wavefront state register block for the fetch stage. It is the successor to the single-port 40x11 PC store. Adds:
- configurable depth, width and read-port count
- two write ports with fixed priority
- per-entry valid bits with single-entry invalidate and bulk clear
- registered reads with optional write-to-read bypass
- a live count of valid entries, used by fetch to know how many wavefronts are resident.

Parameters:
WIDTH, 11, data bits per entry
DEPTH, 40, number of entries (1..2**ADDR_W)
ADDR_W, 6, entry address width
NUM_RD, 2, number of read ports
CNT_W, 7, width of valid_count; must hold DEPTH
BYPASS, 1, 1 = a same-cycle write to the read address is forwarded to the read result; 0 = the read returns the pre-write value

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-low
wr0_en  in  1  write port 0 enable
wr0_addr  in  ADDR_W  write port 0 entry
wr0_data  in  WIDTH  write port 0 data
wr1_en  in  1  write port 1 enable (higher priority)
wr1_addr  in  ADDR_W  write port 1 entry
wr1_data  in  WIDTH  write port 1 data
inv_en  in  1  invalidate one entry
inv_addr  in  ADDR_W  entry to invalidate
clear_all  in  1  invalidate all entries
rd_en  in  NUM_RD  per-port read request
rd_addr  in  NUM_RD*ADDR_W  packed read addresses; port i uses bits [i*ADDR_W +: ADDR_W]
rd_data  out  NUM_RD*WIDTH  packed registered read data
rd_valid  out  NUM_RD  entry-valid flag returned with rd_data
rd_ack  out  NUM_RD  one-cycle pulse marking rd_data/rd_valid as updated
valid_count  out  CNT_W  number of valid entries

Behaviour:
- Reset (rst low, asynchronous, any cycle including mid-operation) clears:
  - all entry data and valid bits
  - rd_data, rd_valid, rd_ack
  - valid_count
  After rst rises, the first edge behaves normally.
- Write:
  - On an edge with wrN_en=1 and addr<DEPTH: entry data <= wrN_data and valid <= 1.
  - A write to addr>=DEPTH is silently dropped.
- Same-edge precedence per entry: clear_all > inv > wr1 > wr0.
  - wr0 and wr1 to the same entry: wr1 data stored.
  - inv and a write to the same entry: entry ends invalid and its data is unchanged.
  - clear_all clears every valid bit and leaves data unchanged.
- Invalidate: inv_en=1 with inv_addr<DEPTH clears that valid bit; out of range is ignored.
- Read latency is 1 cycle:
  - rd_en[i] sampled at edge k updates rd_data/rd_valid[i] at edge k; both are visible during cycle k+1.
  - rd_ack[i]=1 for exactly that cycle.
  - When rd_en[i]=0, rd_ack[i]=0 and rd_data/rd_valid[i] hold their last value.
- Read value:
  - Entry valid: rd_data = entry data and rd_valid=1.
  - Entry invalid or addr>=DEPTH: rd_data=0 and rd_valid=0.
  - All ports are independent; any ports may read the same entry.
- Bypass:
  - BYPASS=1: the read result equals the post-edge entry state, i.e. it honours the precedence above, including inv/clear_all.
  - BYPASS=0: the read result is the pre-edge entry state.
- valid_count: registered, updated on the same edge as the valid bits, equal to the popcount of the post-edge valid vector. Range is 0..DEPTH, with no wrap.
- No state machine. State consists of:
  - the data array
  - the valid vector
  - the read output registers
  - the count register

Decomposition:
- Shared package fetch_pkg holds:
  - the default WIDTH/DEPTH/ADDR_W constants
  - a wf_id_t typedef (ADDR_W bits)
- One sub-module, wf_regblock_rdport, is instantiated NUM_RD times via generate. Each instance contains:
  - the address-range check
  - the bypass/priority resolve mux
  - the output register with rd_ack
- The top level holds:
  - the array
  - the valid vector
  - the write/invalidate priority logic
  - the popcount

Test Plan:
- Reset hold: drive writes and reads during rst=0, then release -> all outputs 0; reading entry 5 returns rd_valid=0, rd_data=0, rd_ack=1 one cycle later.
- Write/read: wr0 entry 3 = 11'h155; next cycle read port 0 entry 3 and port 1 entry 39 (unwritten) -> port0 returns 11'h155 with valid=1; port1 returns 0 with valid=0; valid_count=1.
- Collision priority: same edge, wr0 entry 7 = 11'h001 and wr1 entry 7 = 11'h7FF -> entry 7 reads 11'h7FF. Same edge, inv 7 and wr1 entry 7 = 11'h002 -> entry 7 invalid, and re-writing it then reading returns the new data only.
- Bypass: BYPASS=1, write entry 10 = 11'h0AA while reading entry 10 on the same edge -> rd_data=11'h0AA, rd_valid=1. Repeat with BYPASS=0 and entry 10 previously 11'h011 -> rd_data=11'h011.
- Bounds: write entry 40 and entry 63 -> valid_count unchanged and no entry altered; read entry 45 -> rd_valid=0, rd_data=0, rd_ack=1.
- Count and clear: write all 40 entries -> valid_count=40. Then clear_all together with wr0 entry 0 -> valid_count=0, and entry 0 reads invalid.
